// File: rtl/mk14_rx_loader.sv
// ---------------------------------------------------------------------------
// mk14_rx_loader
//
// Serial program loader for the MK14 SoC. Receives 8N1 UART bytes on `rx`,
// parses frames of the form
//     0x55, ADDR_HI, ADDR_LO, LEN, LEN x DATA, CSUM      (LEN = 0 -> 256)
// and turns each DATA byte into a one-cycle RAM write. The 8-bit sum of
// ADDR_HI through CSUM must be 0x00 for the frame to count as good.
//
// Optional feature macro: MK14_LOADER_EXEC_EN
//   defined   : a good frame also pulses exec_req with exec_addr = the
//               frame start address (held until the next good frame).
//   undefined : exec_req / exec_addr are tied to zero.
//
// Parameters
//   CLOCK_FREQ_MHZ  clk frequency in MHz
//   BAUD_RATE       UART bit rate
//   TIMEOUT_MS      longest inter-byte gap tolerated inside a frame
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous UART line, idle high
//   rx_wait    out  high from sync byte accepted until frame end / abort
//   mem_wr_en  out  one-cycle write strobe
//   mem_addr   out  write address (held between writes)
//   mem_data   out  write data (held between writes)
//   load_done  out  one-cycle pulse, frame ended with a good checksum
//   load_err   out  sticky error; cleared by the next sync byte or rst
//   exec_req   out  one-cycle execute request (feature macro only)
//   exec_addr  out  execute address (feature macro only)
// ---------------------------------------------------------------------------
module mk14_rx_loader #(
    parameter int CLOCK_FREQ_MHZ = 27,
    parameter int BAUD_RATE      = 115200,
    parameter int TIMEOUT_MS     = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        rx_wait,
    output logic        mem_wr_en,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        load_done,
    output logic        load_err,
    output logic        exec_req,
    output logic [15:0] exec_addr
);

    // Rounded clocks-per-bit and derived counter limits.
    localparam int DIV       = (CLOCK_FREQ_MHZ * 1000000 + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF      = DIV / 2;
    localparam int CNT_W     = $clog2(DIV + 1);
    localparam int TMO_LIMIT = TIMEOUT_MS * CLOCK_FREQ_MHZ * 1000;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_LIMIT - 1);

    localparam logic [7:0] SYNC_BYTE = 8'h55;

    // -----------------------------------------------------------------------
    // UART receiver
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]       rx_bit_q,   rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;

    // Combinational strobes, valid in the stop-bit sample cycle only.
    logic byte_valid;
    logic frame_err;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            // The synchronizer resets to the idle-line level so leaving
            // reset does not look like a falling edge.
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;

        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                // A true falling edge, so a line held low after a framing
                // error does not restart the receiver.
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // High at mid-start-bit means the edge was a glitch.
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};   // LSB first
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    // Back in idle on the next cycle, ready for a start bit
                    // that follows the stop bit with no gap.
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame parser
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        P_IDLE,
        P_ADDR_HI,
        P_ADDR_LO,
        P_LEN,
        P_DATA,
        P_CSUM
    } p_state_t;

    p_state_t         p_state_q, p_state_d;
    logic [15:0]      ptr_q,     ptr_d;
    logic [8:0]       remain_q,  remain_d;
    logic [7:0]       sum_q,     sum_d;
    logic [TMO_W-1:0] tmo_q,     tmo_d;
    logic             rx_wait_q, rx_wait_d;
    logic             wr_en_q,   wr_en_d;
    logic [15:0]      addr_q,    addr_d;
    logic [7:0]       data_q,    data_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;

    logic [7:0] sum_next;
    logic       csum_good;
    logic       tmo_expire;

    assign sum_next  = sum_q + rx_shift_q;
    assign csum_good = byte_valid && (p_state_q == P_CSUM) && (sum_next == 8'h00);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_expire = (p_state_q != P_IDLE) && !byte_valid && (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_q <= P_IDLE;
            ptr_q     <= '0;
            remain_q  <= '0;
            sum_q     <= '0;
            tmo_q     <= '0;
            rx_wait_q <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            ptr_q     <= ptr_d;
            remain_q  <= remain_d;
            sum_q     <= sum_d;
            tmo_q     <= tmo_d;
            rx_wait_q <= rx_wait_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        p_state_d = p_state_q;
        ptr_d     = ptr_q;
        remain_d  = remain_q;
        sum_d     = sum_q;
        rx_wait_d = rx_wait_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = err_q;

        // Inter-byte gap counter: idle holds it at zero, every byte restarts it.
        if (p_state_q == P_IDLE || byte_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (byte_valid) begin
            // Running sum covers ADDR_HI..CSUM; the sync byte resets it below.
            sum_d = sum_next;
            unique case (p_state_q)
                P_IDLE: begin
                    if (rx_shift_q == SYNC_BYTE) begin
                        p_state_d = P_ADDR_HI;
                        rx_wait_d = 1'b1;
                        err_d     = 1'b0;
                        sum_d     = 8'h00;
                    end
                end
                P_ADDR_HI: begin
                    ptr_d[15:8] = rx_shift_q;
                    p_state_d   = P_ADDR_LO;
                end
                P_ADDR_LO: begin
                    ptr_d[7:0] = rx_shift_q;
                    p_state_d  = P_LEN;
                end
                P_LEN: begin
                    remain_d  = (rx_shift_q == 8'h00) ? 9'd256 : {1'b0, rx_shift_q};
                    p_state_d = P_DATA;
                end
                P_DATA: begin
                    wr_en_d  = 1'b1;
                    addr_d   = ptr_q;
                    data_d   = rx_shift_q;
                    ptr_d    = ptr_q + 16'd1;     // wraps 0xFFFF -> 0x0000
                    remain_d = remain_q - 9'd1;
                    if (remain_q == 9'd1) begin
                        p_state_d = P_CSUM;
                    end
                end
                P_CSUM: begin
                    // Written bytes stay written whatever the checksum says.
                    p_state_d = P_IDLE;
                    rx_wait_d = 1'b0;
                    if (csum_good) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    p_state_d = P_IDLE;
                end
            endcase
        end else if ((p_state_q != P_IDLE) && (frame_err || tmo_expire)) begin
            p_state_d = P_IDLE;
            rx_wait_d = 1'b0;
            err_d     = 1'b1;
        end
    end

    assign rx_wait   = rx_wait_q;
    assign mem_wr_en = wr_en_q;
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign load_done = done_q;
    assign load_err  = err_q;

    // -----------------------------------------------------------------------
    // Optional execute request
    // -----------------------------------------------------------------------
`ifdef MK14_LOADER_EXEC_EN
    logic [15:0] start_addr_q;
    logic [15:0] exec_addr_q;
    logic        exec_req_q;
    logic        addr_lo_load;

    // Captures ADDR_HI:ADDR_LO as received, before DATA moves the pointer.
    assign addr_lo_load = byte_valid && (p_state_q == P_ADDR_LO);

    always_ff @(posedge clk) begin
        if (rst) begin
            start_addr_q <= '0;
            exec_addr_q  <= '0;
            exec_req_q   <= 1'b0;
        end else begin
            exec_req_q <= csum_good;
            if (addr_lo_load) begin
                start_addr_q <= {ptr_q[15:8], rx_shift_q};
            end
            if (csum_good) begin
                exec_addr_q <= start_addr_q;
            end
        end
    end

    assign exec_req  = exec_req_q;
    assign exec_addr = exec_addr_q;
`else
    assign exec_req  = 1'b0;
    assign exec_addr = 16'h0000;
`endif

endmodule
